// File: rtl/cvp14_mem_pkg.sv
// Shared types and helpers for the CVP14 data-memory controller.
// Parity storage is enabled by defining DRAM_PARITY_EN.
package cvp14_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dram_state_t;

    // Widest data word the parity helper covers; narrower words are zero-extended.
    localparam int PAR_MAX_W = 64;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dram_array.sv
// Storage array for dram_wait_ctrl: synchronous write port and registered read port.
// With DRAM_PARITY_EN defined each word carries an extra even-parity bit.
module dram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              in_range_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              inj_err_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              perr_o
);
    import cvp14_mem_pkg::*;

`ifdef DRAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              rd_perr_s;
    logic [DATA_W-1:0] rdata_q;
    logic              perr_q;

`ifdef DRAM_PARITY_EN
    // Stored parity bit is flipped on request so the checker can be exercised.
    assign wr_word_s = {even_parity(PAR_MAX_W'(wdata_i)) ^ inj_err_i, wdata_i};
    assign rd_perr_s = in_range_i & (^rd_word_s);
`else
    logic unused_inj_s;
    assign unused_inj_s = inj_err_i;
    assign wr_word_s    = wdata_i;
    assign rd_perr_s    = 1'b0;
`endif

    assign rd_word_s = mem_q[idx_i];
    assign rd_data_s = in_range_i ? rd_word_s[DATA_W-1:0] : {DATA_W{1'b0}};

    // Array contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wr_word_s;
        end
    end

    // Read data and parity flag hold until the next read completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= {DATA_W{1'b0}};
            perr_q  <= 1'b0;
        end else if (re_i) begin
            rdata_q <= rd_data_s;
            perr_q  <= rd_perr_s;
        end else begin
            rdata_q <= rdata_q;
            perr_q  <= perr_q;
        end
    end

    assign rdata_o = rdata_q;
    assign perr_o  = perr_q;

endmodule

// File: rtl/dram_wait_ctrl.sv
// CVP14 data memory with Req/Rdy/Done handshake and configurable access latency.
// Optional per-word parity checking is enabled by defining DRAM_PARITY_EN.
module dram_wait_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic              Clk_i,
    input  logic              Rst_i,
    input  logic              RD_i,
    input  logic              WR_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] DataIn_i,
    input  logic              InjErr_i,
    output logic              Rdy_o,
    output logic              Done_o,
    output logic [DATA_W-1:0] DataOut_o,
    output logic              ParityErr_o
);
    import cvp14_mem_pkg::*;

    localparam int                CNT_W    = $clog2(LATENCY + 1);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    dram_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              inj_q, inj_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              complete_s;
    logic              in_range_s;
    logic              we_s;
    logic              re_s;

    // Next-state logic: request latch on acceptance, wait counting while busy.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        inj_d      = inj_q;
        addr_d     = addr_q;
        data_d     = data_q;
        complete_s = 1'b0;
        case (state_q)
            IDLE: begin
                if ((RD_i | WR_i) & rdy_q) begin
                    state_d = ACCESS;
                    cnt_d   = {CNT_W{1'b0}};
                    rd_d    = RD_i & ~WR_i;   // simultaneous RD/WR is a write
                    wr_d    = WR_i;
                    inj_d   = InjErr_i;
                    addr_d  = Addr_i;
                    data_d  = DataIn_i;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d    = IDLE;
                    complete_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d  = (state_d == IDLE);
        done_d = complete_s;
    end

    // Controller state; a reset mid-access simply abandons the latched request.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            inj_q   <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            inj_q   <= inj_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign in_range_s = ({1'b0, addr_q} < DEPTH_L);
    assign we_s       = complete_s & wr_q & in_range_s & ~Rst_i;
    assign re_s       = complete_s & rd_q & ~Rst_i;

    dram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i      (Clk_i),
        .rst_i      (Rst_i),
        .we_i       (we_s),
        .re_i       (re_s),
        .in_range_i (in_range_s),
        .idx_i      (addr_q[IDX_W-1:0]),
        .wdata_i    (data_q),
        .inj_err_i  (inj_q),
        .rdata_o    (DataOut_o),
        .perr_o     (ParityErr_o)
    );

    assign Rdy_o  = rdy_q;
    assign Done_o = done_q;

endmodule

// File: tb/tb_dram_wait_ctrl.sv
// Directed plus randomized bench for dram_wait_ctrl against a word-level memory model.
// Parity scenarios are included when DRAM_PARITY_EN is defined.
module tb_dram_wait_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;
`ifdef DRAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd;
    logic          wr;
    logic          inj;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rdy;
    logic          done;
    logic          perr;
    logic [DW-1:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem_m [DEPTH];
    bit            badpar_m [DEPTH];
    logic [DW-1:0] exp_dout;
    logic          exp_perr;
    time           t_prev;
    time           t_acc;

    dram_wait_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .Clk_i       (clk),
        .Rst_i       (rst),
        .RD_i        (rd),
        .WR_i        (wr),
        .Addr_i      (addr),
        .DataIn_i    (din),
        .InjErr_i    (inj),
        .Rdy_o       (rdy),
        .Done_o      (done),
        .DataOut_o   (dout),
        .ParityErr_o (perr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level memory behaviour: writes win over reads, out-of-range is a hole reading 0.
    function automatic void model_apply(input logic r, input logic w, input logic [AW-1:0] a,
                                        input logic [DW-1:0] d, input logic i);
        bit hit;
        hit = (int'(a) < DEPTH);
        if (w) begin
            if (hit) begin
                mem_m[a[3:0]]    = d;
                badpar_m[a[3:0]] = PAR_EN && i;
            end
        end else if (r) begin
            exp_dout = hit ? mem_m[a[3:0]] : '0;
            exp_perr = hit ? badpar_m[a[3:0]] : 1'b0;
        end
    endfunction

    task automatic do_access(input logic r, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic i, input string tag,
                             output time tacc);
        int waited = 0;
        while (rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
        rd = r; wr = w; addr = a; din = d; inj = i;
        @(posedge clk);
        tacc = $time;
        @(negedge clk);
        model_apply(r, w, a, d, i);
        for (int k = 0; k < LAT; k++) begin
            chk({tag, "_busy_done"}, 32'(done), 32'd0);
            chk({tag, "_busy_rdy"}, 32'(rdy), 32'd0);
            // Requests while busy must be ignored.
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = AW'($urandom);
            din  = DW'($urandom);
            inj  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rd = 1'b0; wr = 1'b0; inj = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_rdy_on_done"}, 32'(rdy), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        chk({tag, "_perr"}, 32'(perr), 32'(exp_perr));
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; inj = 1'b0; addr = '0; din = '0;
        exp_dout = '0; exp_perr = 1'b0;
        for (int i = 0; i < DEPTH; i++) badpar_m[i] = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_perr", 32'(perr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", 32'(rdy), 32'd1);

        // Fill every word back-to-back; accepts must be LAT+1 cycles apart.
        for (int i = 0; i < DEPTH; i++) begin
            do_access(1'b0, 1'b1, AW'(i), DW'($urandom), 1'b0, "fill", t_acc);
            if (i > 0) chk("b2b_gap", 32'((t_acc - t_prev) / 10), 32'(LAT + 1));
            t_prev = t_acc;
        end
        for (int i = 0; i < 4; i++) do_access(1'b1, 1'b0, AW'(i), '0, 1'b0, "readback", t_acc);

        do_access(1'b0, 1'b1, 16'd3, 16'hBEEF, 1'b0, "wr_beef", t_acc);
        do_access(1'b1, 1'b0, 16'd3, 16'h0000, 1'b0, "rd_beef", t_acc);
        chk("beef_value", 32'(dout), 32'h0000BEEF);

        do_access(1'b0, 1'b1, 16'd20, 16'h1234, 1'b0, "wr_oor", t_acc);
        do_access(1'b1, 1'b0, 16'd20, 16'h0000, 1'b0, "rd_oor", t_acc);
        chk("oor_zero", 32'(dout), 32'd0);
        do_access(1'b1, 1'b0, 16'd4, 16'h0000, 1'b0, "rd_4", t_acc);

        do_access(1'b1, 1'b0, 16'd6, 16'h0000, 1'b0, "rd_6", t_acc);
        do_access(1'b1, 1'b1, 16'd9, 16'h5A5A, 1'b0, "rdwr_9", t_acc);
        do_access(1'b1, 1'b0, 16'd9, 16'h0000, 1'b0, "rd_9", t_acc);
        chk("rdwr_wrote", 32'(dout), 32'h00005A5A);

        // Reset one cycle after acceptance: no completion, no commit.
        wr = 1'b1; addr = 16'd5; din = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rdy", 32'(rdy), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        exp_dout = '0; exp_perr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_rdy_back", 32'(rdy), 32'd1);
        do_access(1'b1, 1'b0, 16'd5, 16'h0000, 1'b0, "rd_abort", t_acc);

`ifdef DRAM_PARITY_EN
        do_access(1'b0, 1'b1, 16'd7, 16'h0001, 1'b1, "wr_inj", t_acc);
        do_access(1'b1, 1'b0, 16'd7, 16'h0000, 1'b0, "rd_inj", t_acc);
        chk("parity_flag", 32'(perr), 32'd1);
        do_access(1'b0, 1'b1, 16'd7, 16'h0001, 1'b0, "wr_clean", t_acc);
        do_access(1'b1, 1'b0, 16'd7, 16'h0000, 1'b0, "rd_clean", t_acc);
        chk("parity_clear", 32'(perr), 32'd0);
`endif

        for (int n = 0; n < 150; n++) begin
            logic r;
            logic w;
            r = 1'($urandom_range(0, 1));
            w = r ? 1'($urandom_range(0, 1)) : 1'b1;
            do_access(r, w, AW'($urandom_range(0, 23)), DW'($urandom),
                      1'($urandom_range(0, 1)), "rand", t_acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
